// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// State codes are plain localparams so legacy tools can consume them.
package prog_loader_pkg;

    localparam int unsigned StateW = 3;
    typedef logic [StateW-1:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StLoad  = 3'd1;
    localparam state_t StCheck = 3'd2;
    localparam state_t StDelay = 3'd3;
    localparam state_t StRun   = 3'd4;
    localparam state_t StError = 3'd5;

    localparam int unsigned LEN_ZERO_MEANS = 256;
    localparam int unsigned CntW           = 9;
    localparam int unsigned DlyW           = 4;

    typedef logic [CntW-1:0] cnt_t;
    typedef logic [DlyW-1:0] dly_t;

    // A length byte of zero encodes a full 256-byte image.
    function automatic cnt_t decode_len(input logic [7:0] len_byte);
        return (len_byte == 8'd0) ? cnt_t'(LEN_ZERO_MEANS) : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader side uses the slave modport; the stream source uses master.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/prog_loader_csum.sv
// Modulo-256 payload accumulator with synchronous clear and an equality
// compare against the incoming checksum byte.
module prog_loader_csum (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] data,
    input  logic [7:0] cmp_data,
    output logic       match
);
    logic [7:0] sum_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
        end else if (add) begin
            sum_q <= sum_q + data;
        end
    end

    assign match = (sum_q == cmp_data);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length byte, payload written to instruction memory, optional
// checksum (PROG_LOADER_CHECKSUM_EN), then delayed release of the CPU reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned RELEASE_DLY = 4
) (
    input  logic            clk,
    input  logic            rstn,
    prog_loader_if.slave    bus,
    output logic            cpu_rstn,
    output logic            done,
    output logic            err
);
    localparam logic [ADDR_W-1:0] BaseAddr = BASE_ADDR[ADDR_W-1:0];
    localparam dly_t              DlyLast  = dly_t'(RELEASE_DLY);

    state_t            state_q, state_d;
    cnt_t              remain_q, remain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    dly_t              dly_q, dly_d;

    logic              in_ready_q, in_ready_d;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_rstn_q, cpu_rstn_d;

    logic fire, len_acc, pay_acc, last_pay;

    assign fire     = bus.in_valid & in_ready_q;
    assign len_acc  = fire & ((state_q == StIdle) | (state_q == StError));
    assign pay_acc  = fire & (state_q == StLoad);
    assign last_pay = pay_acc & (remain_q == cnt_t'(1));

`ifdef PROG_LOADER_CHECKSUM_EN
    logic match, bad_q, err_q;

    prog_loader_csum u_csum (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (len_acc),
        .add      (pay_acc),
        .data     (bus.in_data),
        .cmp_data (bus.in_data),
        .match    (match)
    );

    // A bad checksum is flagged one edge after it is accepted; a new length
    // byte accepted on that same edge still wins and keeps err low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bad_q <= fire & (state_q == StCheck) & ~match;
            if (len_acc) begin
                err_q <= 1'b0;
            end else if (bad_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        addr_d   = addr_q;
        dly_d    = dly_q;
        case (state_q)
            StIdle, StError: begin
                if (fire) begin
                    state_d  = StLoad;
                    remain_d = decode_len(bus.in_data);
                    addr_d   = BaseAddr;
                end
            end
            StLoad: begin
                if (fire) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - cnt_t'(1);
                    if (last_pay) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        state_d = StDelay;
`endif
                        dly_d   = '0;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            StCheck: begin
                if (fire) begin
                    state_d = match ? StDelay : StError;
                    dly_d   = '0;
                end
            end
`endif
            StDelay: begin
                if (dly_q == DlyLast) begin
                    state_d = StRun;
                end else begin
                    dly_d = dly_q + dly_t'(1);
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_d  = (state_d == StIdle) | (state_d == StLoad) |
                      (state_d == StCheck) | (state_d == StError);
        mem_addr_d  = pay_acc ? addr_q : mem_addr_q;
        mem_wdata_d = pay_acc ? bus.in_data : mem_wdata_q;
        cpu_rstn_d  = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            remain_q    <= '0;
            addr_q      <= BaseAddr;
            dly_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BaseAddr;
            mem_wdata_q <= '0;
            cpu_rstn_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            addr_q      <= addr_d;
            dly_q       <= dly_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= pay_acc;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rstn_q  <= cpu_rstn_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_rstn      = cpu_rstn_q;
    assign done          = cpu_rstn_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the single-cycle 8-bit CPU wrapper. It accepts a byte stream (length byte, payload, optional checksum), writes the payload into the CPU instruction memory's write port starting at a fixed base address, and holds the CPU in reset until the image is complete and verified. It replaces hierarchical memory preloading with a synthesizable boot path.

## Interface
- ADDR_W, 8, instruction-memory address width; addresses wrap modulo 2^ADDR_W
- BASE_ADDR, 0, address of the first payload byte
- RELEASE_DLY, 4, cycles between image accepted and cpu_rstn rising; legal range 1..15
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte; registered
- mem_we  out  1  instruction-memory write strobe, one-cycle pulse
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- cpu_rstn  out  1  active-low reset to the CPU wrapper; registered
- done  out  1  image loaded, CPU released; sticky until rstn
- err  out  1  checksum mismatch; sticky until the next length byte is accepted

## Operation
- Transfer occurs on a rising edge with in_valid=1 and in_ready=1. in_data must stay stable while in_valid=1 and in_ready=0.
- States: IDLE, LOAD, CHECK, DELAY, RUN, ERROR.
- IDLE: the accepted byte is the length N. N=0 means 256. Clear the byte counter and sum, set the address to BASE_ADDR, go to LOAD.
- LOAD: for each accepted byte:
  - write it at the current address; the address increments and wraps;
  - sum += byte, mod 256;
  - after the Nth byte, go to CHECK.
- CHECK: the accepted byte is compared with the sum.
  - Equal: go to DELAY.
  - Unequal: go to ERROR and set err.
- ERROR: cpu_rstn stays 0. The next accepted byte is treated as a new length byte (IDLE semantics), clears err, and goes to LOAD.
- DELAY: in_ready=0. Count RELEASE_DLY cycles, then go to RUN.
- RUN: cpu_rstn=1, done=1, in_ready=0 permanently; in_valid is ignored. Only rstn leaves RUN.
- Memory contents are never erased. A partial image left by an error or a reset stays in memory and is overwritten by the next load.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rstn=0, done=0, err=0. The state machine resets to IDLE.
- in_ready rises on the first rising edge after rstn deasserts. It is 1 in IDLE, LOAD, CHECK and ERROR.
- Write latency: a payload byte accepted at edge k drives mem_we=1 with its mem_addr and mem_wdata for exactly the cycle following edge k. One write per accepted byte; back-to-back bytes give back-to-back write pulses.
- in_ready falls on the same edge that accepts the checksum byte (or the last payload byte when the checksum is compiled out).
- cpu_rstn rises RELEASE_DLY+1 edges after that final accepting edge; done rises on the same edge. The last memory write has always completed before release.
- err rises on the edge after the bad checksum byte is accepted.
- rstn asserted mid-load: all outputs return to reset values immediately and asynchronously, and the next byte after release is a length byte.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined: the CHECK state exists and err can assert.
- Undefined: after the Nth payload byte go directly to DELAY. The sum logic is removed and err is tied to 0.

## Structure
- prog_loader_pkg holds:
  - the state enum;
  - LEN_ZERO_MEANS = 256;
  - the counter width for the 9-bit payload count;
  - the RELEASE_DLY counter width (4 bits).
- Sub-module prog_loader_csum: 8-bit accumulator with clear, add-enable and compare output. It is instantiated only under PROG_LOADER_CHECKSUM_EN.

## Test plan
- Stream 03, 04, F0, 04, checksum F8 → writes at addresses 0/1/2 with data 04/F0/04. cpu_rstn and done rise 5 edges after the F8 byte is accepted; err stays 0.
- Same stream with checksum 00 → err=1, cpu_rstn stays 0. Then stream 01, AA, AA → err clears, address 0 is rewritten with AA, and the CPU is released.
- Length 00 followed by 256 bytes of value i → 256 writes, the address wraps from FF to 00, and the sum checks correctly.
- Toggle in_valid randomly during a load → exactly N mem_we pulses with no duplicate or skipped addresses. in_ready stays 0 after release even with in_valid held high.
- Assert rstn after 2 of 5 payload bytes → outputs return to reset values the same cycle. A fresh 02, 11, 22, 33 stream loads at BASE_ADDR.
- With PROG_LOADER_CHECKSUM_EN undefined: stream 02, 11, 22 → release follows the byte 22 with no checksum byte consumed.
